// File: rtl/ase_idle_tracker_pkg.sv
// Shared types and default parameter values for the ASE idle tracker.
package ase_idle_tracker_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DRAIN    = 2'd1,
        QUIESCED = 2'd2
    } idle_state_e;

    localparam int DEF_MAX_OUTSTANDING  = 1024;
    localparam int DEF_IDLE_HOLD_CYCLES = 16;
    localparam int DEF_DRAIN_TIMEOUT    = 65536;

endpackage

// File: rtl/ase_outstanding_counter.sv
// In-flight transaction counter for one channel. The counter saturates at
// MAX_OUTSTANDING and stops at zero. A forced overflow or a response with
// nothing in flight sets the sticky err flag.
module ase_outstanding_counter
    import ase_idle_tracker_pkg::*;
#(
    parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             err
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    logic [CNT_W-1:0] count_q, count_d;
    logic             err_q, err_d;

    // Next count: an accept and a completion in the same cycle cancel out.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
        count_d = count_q;
        err_d   = err_q;
        if (inc && !dec) begin
            if (count_q == MAX_CNT) err_d   = 1'b1;
            else                    count_d = count_q + CNT_W'(1);
        end else if (dec && !inc) begin
            if (count_q == '0)      err_d   = 1'b1;
            else                    count_d = count_q - CNT_W'(1);
        end
    end

    // Count and sticky error registers.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state registers use non-blocking assignments so all flops sample the same pre-edge values.
        if (reset) begin
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign count = count_q;
    assign err   = err_q;

endmodule

// File: rtl/ase_idle_tracker.sv
// Tracks in-flight reads and writes between the host and the AFU. It reports
// system_is_idle after a run of quiet cycles. During lockdown it blocks new
// requests, drains, and reports completion or timeout.
module ase_idle_tracker
    import ase_idle_tracker_pkg::*;
#(
    parameter int MAX_OUTSTANDING  = DEF_MAX_OUTSTANDING,
    parameter int CNT_W            = $clog2(MAX_OUTSTANDING + 1),
    parameter int IDLE_HOLD_CYCLES = DEF_IDLE_HOLD_CYCLES,
    parameter int DRAIN_TIMEOUT    = DEF_DRAIN_TIMEOUT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             lockdown,
    input  logic             rd_req_valid,
    output logic             rd_req_ready,
    input  logic             rd_rsp_valid,
    input  logic             wr_req_valid,
    output logic             wr_req_ready,
    input  logic             wr_rsp_valid,
    output logic [CNT_W-1:0] rd_outstanding,
    output logic [CNT_W-1:0] wr_outstanding,
    output logic             system_is_idle,
    output logic             drain_done,
    output logic             drain_timeout,
    output logic             cnt_error
);

    localparam int               IDLE_W   = $clog2(IDLE_HOLD_CYCLES + 1);
    localparam int               TMO_W    = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_HOLD_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(DRAIN_TIMEOUT - 1);

    idle_state_e       state_q, state_d;
    logic              alive_q;
    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
    logic              idle_q, idle_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              done_q, done_d;
    logic              timeout_q, timeout_d;

    logic can_accept, rd_acc, wr_acc, quiet, rd_err, wr_err;

    // alive_q keeps both readies low until the first edge after reset release.
    // This keeps every output at 0 while reset is held.
    assign can_accept   = alive_q && (state_q == RUN) && !lockdown;
    assign rd_req_ready = can_accept && (rd_outstanding < MAX_CNT);
    assign wr_req_ready = can_accept && (wr_outstanding < MAX_CNT);
    assign rd_acc       = rd_req_valid && rd_req_ready;
    assign wr_acc       = wr_req_valid && wr_req_ready;

    assign quiet = (rd_outstanding == '0) && (wr_outstanding == '0) &&
                   !rd_acc && !wr_acc && !rd_rsp_valid && !wr_rsp_valid;

    ase_outstanding_counter #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .CNT_W           (CNT_W)
    ) u_rd_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (rd_acc),
        .dec   (rd_rsp_valid),
        .count (rd_outstanding),
        .err   (rd_err)
    );

    ase_outstanding_counter #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .CNT_W           (CNT_W)
    ) u_wr_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (wr_acc),
        .dec   (wr_rsp_valid),
        .count (wr_outstanding),
        .err   (wr_err)
    );

    // Idle-hold counter: counts quiet cycles up to the hold limit and restarts on any activity.
    always_comb begin
        idle_cnt_d = idle_cnt_q;
        if (!quiet)                   idle_cnt_d = '0;
        else if (idle_cnt_q != IDLE_MAX) idle_cnt_d = idle_cnt_q + IDLE_W'(1);
        idle_d = (idle_cnt_d == IDLE_MAX);
    end

    // Lockdown FSM: next state, drain timer, and completion flags.
    always_comb begin
        state_d   = state_q;
        tmo_d     = tmo_q;
        done_d    = 1'b0;
        timeout_d = timeout_q;
        case (state_q)
            RUN: begin
                if (lockdown) begin
                    state_d = DRAIN;
                    tmo_d   = '0;
                end
            end
            DRAIN: begin
                if (!lockdown) begin
                    state_d = RUN;
                    tmo_d   = '0;
                end else if (idle_q) begin
                    state_d = QUIESCED;
                    done_d  = 1'b1;
                end else if (tmo_q == TMO_LAST) begin
                    state_d   = QUIESCED;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            QUIESCED: begin
                if (!lockdown) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    // State, timer, idle and flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= RUN;
            alive_q    <= 1'b0;
            idle_cnt_q <= '0;
            idle_q     <= 1'b0;
            tmo_q      <= '0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            alive_q    <= 1'b1;
            idle_cnt_q <= idle_cnt_d;
            idle_q     <= idle_d;
            tmo_q      <= tmo_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
        end
    end

    assign system_is_idle = idle_q;
    assign drain_done     = done_q;
    assign drain_timeout  = timeout_q;
    assign cnt_error      = rd_err || wr_err;

endmodule

// File: tb/tb_ase_idle_tracker.sv
// Scoreboard testbench for ase_idle_tracker. The driver predicts each cycle's
// outputs from a transaction-level model and queues them. A negedge monitor
// compares the DUT against the queued values.
module tb_ase_idle_tracker;

    localparam int MAX     = 8;
    localparam int CNT_W   = $clog2(MAX + 1);
    localparam int HOLD    = 16;
    localparam int TIMEOUT = 100;

    logic clk = 1'b0;
    logic reset, lockdown;
    logic rd_req_valid, rd_rsp_valid, wr_req_valid, wr_rsp_valid;
    logic rd_req_ready, wr_req_ready;
    logic [CNT_W-1:0] rd_outstanding, wr_outstanding;
    logic system_is_idle, drain_done, drain_timeout, cnt_error;

    always #5 clk = ~clk;

    ase_idle_tracker #(
        .MAX_OUTSTANDING  (MAX),
        .CNT_W            (CNT_W),
        .IDLE_HOLD_CYCLES (HOLD),
        .DRAIN_TIMEOUT    (TIMEOUT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .lockdown       (lockdown),
        .rd_req_valid   (rd_req_valid),
        .rd_req_ready   (rd_req_ready),
        .rd_rsp_valid   (rd_rsp_valid),
        .wr_req_valid   (wr_req_valid),
        .wr_req_ready   (wr_req_ready),
        .wr_rsp_valid   (wr_rsp_valid),
        .rd_outstanding (rd_outstanding),
        .wr_outstanding (wr_outstanding),
        .system_is_idle (system_is_idle),
        .drain_done     (drain_done),
        .drain_timeout  (drain_timeout),
        .cnt_error      (cnt_error)
    );

    typedef struct {
        bit rd_rdy;
        bit wr_rdy;
        int rd_cnt;
        int wr_cnt;
        bit idle;
        bit done;
        bit tmo;
        bit err;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: plain transaction counts and a quiet-streak length.
    typedef enum {M_RUN, M_DRAIN, M_QUIESCED} mode_e;
    bit    m_alive;
    int    m_rd, m_wr, m_streak, m_age;
    mode_e m_mode;
    bit    m_done, m_tmo, m_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_alive = 0; m_rd = 0; m_wr = 0; m_streak = 0; m_age = 0;
        m_mode = M_RUN; m_done = 0; m_tmo = 0; m_err = 0;
    endtask

    task automatic chan_update(inout int cnt, input bit acc, input bit rsp);
        if (acc && !rsp) begin
            if (cnt == MAX) m_err = 1; else cnt++;
        end else if (rsp && !acc) begin
            if (cnt == 0) m_err = 1; else cnt--;
        end
    endtask

    // Drives one cycle (called just after a posedge) and advances the model across the next edge.
    task automatic run_cycle(input bit lk, input bit rv, input bit rr, input bit wv, input bit wr);
        exp_t e;
        bit   ra, wa, quiet, idle_now;
        lockdown     = lk;
        rd_req_valid = rv;
        rd_rsp_valid = rr;
        wr_req_valid = wv;
        wr_rsp_valid = wr;
        e.rd_rdy = m_alive && m_mode == M_RUN && !lk && m_rd < MAX;
        e.wr_rdy = m_alive && m_mode == M_RUN && !lk && m_wr < MAX;
        e.rd_cnt = m_rd;
        e.wr_cnt = m_wr;
        e.idle   = (m_streak >= HOLD);
        e.done   = m_done;
        e.tmo    = m_tmo;
        e.err    = m_err;
        exp_q.push_back(e);
        ra = rv && e.rd_rdy;
        wa = wv && e.wr_rdy;
        @(posedge clk);
        quiet    = (m_rd == 0) && (m_wr == 0) && !ra && !wa && !rr && !wr;
        idle_now = (m_streak >= HOLD);
        chan_update(m_rd, ra, rr);
        chan_update(m_wr, wa, wr);
        m_streak = quiet ? ((m_streak < HOLD) ? m_streak + 1 : HOLD) : 0;
        m_done   = 0;
        case (m_mode)
            M_RUN: if (lk) begin m_mode = M_DRAIN; m_age = 0; end
            M_DRAIN: begin
                m_age++;
                if (!lk) m_mode = M_RUN;
                else if (idle_now) begin m_mode = M_QUIESCED; m_done = 1; end
                else if (m_age == TIMEOUT) begin m_mode = M_QUIESCED; m_done = 1; m_tmo = 1; end
            end
            default: if (!lk) m_mode = M_RUN;
        endcase
        m_alive = 1;
        #1;
    endtask

    task automatic quiet_cycles(input int n, input bit lk);
        repeat (n) run_cycle(lk, 0, 0, 0, 0);
    endtask

    // Asserts reset asynchronously and checks that all outputs drop at once.
    task automatic apply_reset(input int n);
        @(posedge clk);
        #1;
        reset = 1'b1;
        lockdown = 0; rd_req_valid = 0; rd_rsp_valid = 0; wr_req_valid = 0; wr_rsp_valid = 0;
        model_reset();
        #1;
        check("rst_rd_ready", rd_req_ready, 0);
        check("rst_wr_ready", wr_req_ready, 0);
        check("rst_rd_cnt", 32'(rd_outstanding), 0);
        check("rst_wr_cnt", 32'(wr_outstanding), 0);
        check("rst_idle", system_is_idle, 0);
        check("rst_done", drain_done, 0);
        check("rst_timeout", drain_timeout, 0);
        check("rst_err", cnt_error, 0);
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Monitor: compares the DUT against the prediction queued for this cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("rd_req_ready", rd_req_ready, e.rd_rdy);
                check("wr_req_ready", wr_req_ready, e.wr_rdy);
                check("rd_outstanding", 32'(rd_outstanding), e.rd_cnt);
                check("wr_outstanding", 32'(wr_outstanding), e.wr_cnt);
                check("system_is_idle", system_is_idle, e.idle);
                check("drain_done", drain_done, e.done);
                check("drain_timeout", drain_timeout, e.tmo);
                check("cnt_error", cnt_error, e.err);
            end
        end
    end

    initial begin
        #500000;
        n_bad++;
        $display("FAIL watchdog: got timeout expected completion at %0t", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        bit rlk;
        reset = 1'b1;
        lockdown = 0; rd_req_valid = 0; rd_rsp_valid = 0; wr_req_valid = 0; wr_rsp_valid = 0;
        model_reset();
        apply_reset(3);

        // Idle rises after the hold period with no traffic.
        quiet_cycles(20, 0);

        // Three reads out, three completions back, then idle again.
        repeat (3) run_cycle(0, 1, 0, 0, 0);
        repeat (3) run_cycle(0, 0, 1, 0, 0);
        quiet_cycles(20, 0);

        // Accept and completion in the same cycle at count 2.
        repeat (2) run_cycle(0, 1, 0, 0, 0);
        repeat (3) run_cycle(0, 1, 1, 0, 0);
        repeat (2) run_cycle(0, 0, 1, 0, 0);
        quiet_cycles(20, 0);

        // Drain with two writes in flight, then leave lockdown.
        repeat (2) run_cycle(0, 0, 0, 1, 0);
        repeat (3) run_cycle(1, 0, 0, 1, 0);
        repeat (2) run_cycle(1, 0, 0, 0, 1);
        quiet_cycles(25, 1);
        run_cycle(0, 0, 0, 1, 0);
        run_cycle(0, 0, 0, 0, 1);
        quiet_cycles(20, 0);

        // Drain timeout with one read that completes late in QUIESCED.
        run_cycle(0, 1, 0, 0, 0);
        quiet_cycles(110, 1);
        run_cycle(1, 0, 1, 0, 0);
        quiet_cycles(5, 1);
        quiet_cycles(20, 0);

        // Randomized traffic with occasional lockdown and quiet windows.
        rlk = 0;
        for (int i = 0; i < 1500; i++) begin
            bit rv, rr, wv, wr;
            if ($urandom_range(0, 59) == 0) rlk = !rlk;
            if ((i / 100) % 3 == 2) begin
                rv = 0; wv = 0;
            end else begin
                rv = $urandom_range(0, 1) == 1;
                wv = $urandom_range(0, 1) == 1;
            end
            rr = (m_rd > 0) && ($urandom_range(0, 99) < 40);
            wr = (m_wr > 0) && ($urandom_range(0, 99) < 40);
            run_cycle(rlk, rv, rr, wv, wr);
        end
        while (m_rd > 0 || m_wr > 0) run_cycle(0, 0, m_rd > 0, 0, m_wr > 0);
        quiet_cycles(20, 0);

        // Underflow error, fill a channel to MAX, then reset mid-drain.
        run_cycle(0, 0, 1, 0, 0);
        quiet_cycles(3, 0);
        repeat (MAX + 3) run_cycle(0, 0, 0, 1, 0);
        run_cycle(0, 1, 0, 0, 0);
        quiet_cycles(30, 1);
        apply_reset(2);
        quiet_cycles(20, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
